ram_cmd_ctrl: RTL and testbench

- Command/response controller that owns port A of the byte-enabled dual-port RAM (DxWb, 1-cycle registered read).
- Zero-fills the whole RAM after reset, then accepts read/write commands over a valid/ready channel.
- Returns read data over a backpressurable response channel and hides the RAM's fixed read latency with a 2-entry skid FIFO.
- Port B of the RAM is not touched by this block.

---
 rtl/ram_cmd_ctrl.sv | 112 +++++++++++
 tb/tb_ram_cmd_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_ctrl.sv
// Port-A owner for a byte-enabled dual-port RAM: zero-fills it after reset, then serves
// read/write commands, with a 2-entry skid FIFO hiding the RAM's one-cycle read latency.
module ram_cmd_ctrl #(
  parameter int  DEPTH          = 2048,
  parameter int  WIDTH          = 32,
  parameter bit  CLEAR_ON_RESET = 1'b1,
  localparam int DEPTH_BITS     = $clog2(DEPTH),
  localparam int BE_BITS        = WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [DEPTH_BITS-1:0] cmd_address,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic [BE_BITS-1:0]    cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  init_done,
  output logic [DEPTH_BITS-1:0] ram_address,
  output logic                  ram_wren,
  output logic [BE_BITS-1:0]    ram_byteena,
  output logic [WIDTH-1:0]      ram_data,
  input  logic [WIDTH-1:0]      ram_q
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                r_state;
  logic [DEPTH_BITS-1:0] r_clr_cnt;
  logic                  r_init_done;
  logic                  r_inflight;
  logic [WIDTH-1:0]      r_fifo_mem [2];
  logic                  r_fifo_rd_ptr;
  logic                  r_fifo_wr_ptr;
  logic [1:0]            r_fifo_cnt;

  logic       w_run;
  logic [1:0] w_used;
  logic       w_accept;
  logic       w_rd_accept;
  logic       w_fifo_empty;
  logic       w_push;
  logic       w_pop;

  // Credits count every read not yet handed out: queued in the FIFO or still in the RAM.
  assign w_run        = !reset && (r_state == ST_RUN);
  assign w_used       = r_fifo_cnt + {1'b0, r_inflight};
  assign cmd_ready    = w_run && (w_used < 2'd2);
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_rd_accept  = w_accept && !cmd_wr;
  assign w_fifo_empty = (r_fifo_cnt == 2'd0);

  assign rsp_valid = !reset && (!w_fifo_empty || r_inflight);
  assign rsp_data  = w_fifo_empty ? ram_q : r_fifo_mem[r_fifo_rd_ptr];
  assign w_pop     = rsp_valid && rsp_ready && !w_fifo_empty;
  // Fresh RAM data bypasses the FIFO only when nothing older is queued and it is taken now.
  assign w_push    = !reset && r_inflight && !(w_fifo_empty && rsp_ready);

  assign init_done = !reset && r_init_done;
  assign ram_wren  = !reset && ((r_state == ST_INIT) || (w_accept && cmd_wr));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    ram_address = cmd_address;
    ram_data    = cmd_data;
    ram_byteena = cmd_mask;
    if (r_state == ST_INIT) begin
      ram_address = r_clr_cnt;
      ram_data    = '0;
      ram_byteena = '1;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values of the others regardless of statement order.
    if (reset) begin
      r_state       <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      r_clr_cnt     <= '0;
      r_init_done   <= !CLEAR_ON_RESET;
      r_inflight    <= 1'b0;
      r_fifo_rd_ptr <= 1'b0;
      r_fifo_wr_ptr <= 1'b0;
      r_fifo_cnt    <= 2'd0;
    end else begin
      if (r_state == ST_INIT) begin
        r_clr_cnt <= r_clr_cnt + DEPTH_BITS'(1);
        if (r_clr_cnt == DEPTH_BITS'(DEPTH - 1)) begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
        end
      end
      r_inflight <= w_rd_accept;
      if (w_push) r_fifo_wr_ptr <= ~r_fifo_wr_ptr;
      if (w_pop)  r_fifo_rd_ptr <= ~r_fifo_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; the count and pointers alone decide what is valid.
  always_ff @(posedge clock) begin
    if (w_push) r_fifo_mem[r_fifo_wr_ptr] <= ram_q;
  end

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Bench for ram_cmd_ctrl: port-A RAM model plus a memory/response-order scoreboard,
// directed scenarios followed by randomized traffic.
module tb_ram_cmd_ctrl;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int AW    = 4;
  localparam int BW    = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             rst_drv = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_wr = 1'b0;
  logic [AW-1:0]    cmd_address = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [BW-1:0]    cmd_mask = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic             init_done;
  logic [AW-1:0]    ram_address;
  logic             ram_wren;
  logic [BW-1:0]    ram_byteena;
  logic [WIDTH-1:0] ram_data;
  logic [WIDTH-1:0] ram_q;

  logic [WIDTH-1:0] ram_arr   [DEPTH];
  logic [WIDTH-1:0] model_mem [DEPTH];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];
  int               got_cyc_q[$];
  int               cyc     = 0;
  int               n_pass  = 0;
  int               n_total = 0;

  always #5 clock = ~clock;

  ram_cmd_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_byteena(ram_byteena),
    .ram_data(ram_data), .ram_q(ram_q)
  );

  // RAM contents are scrambled while reset is high, so only the clear can zero them.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ram_arr[i] <= $urandom;
    end else if (ram_wren) begin
      for (int b = 0; b < BW; b++)
        if (ram_byteena[b]) ram_arr[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
    end
    ram_q <= ram_arr[ram_address];
  end

  // One clock cycle: drive at the falling edge, sample 1 time unit later, update scoreboard.
  task automatic step(input logic v, input logic wr, input logic [AW-1:0] a,
                      input logic [WIDTH-1:0] d, input logic [BW-1:0] m, input logic rr,
                      output logic acc, output logic rdy, output logic rv);
    @(negedge clock);
    reset = rst_drv;
    cmd_valid = v; cmd_wr = wr; cmd_address = a; cmd_data = d; cmd_mask = m;
    rsp_ready = rr;
    #1;
    rdy = cmd_ready;
    rv  = rsp_valid;
    acc = v && (cmd_ready === 1'b1);
    if (acc) begin
      if (wr) begin
        for (int b = 0; b < BW; b++)
          if (m[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
      end else begin
        exp_q.push_back(model_mem[a]);
      end
    end
    if (rsp_valid === 1'b1 && rr) begin
      got_q.push_back(rsp_data);
      got_cyc_q.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic idle(input logic rr);
    logic a, r, v;
    step(1'b0, 1'b0, '0, '0, '0, rr, a, r, v);
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic test_reset();
    logic acc, rdy, rv;
    rst_drv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, '0, '1, '1, 1'b1, acc, rdy, rv);
      n_total++;
      if (rdy !== 1'b0 || rv !== 1'b0 || init_done !== 1'b0 || ram_wren !== 1'b0)
        $display("FAIL reset_outputs cycle %0d: ready=%b rsp_valid=%b init_done=%b wren=%b, required all 0",
                 i, rdy, rv, init_done, ram_wren);
      else n_pass++;
    end
    rst_drv = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, AW'(i), '1, '1, 1'b1, acc, rdy, rv);
      n_total++;
      if (ram_wren !== 1'b1 || ram_address !== AW'(i) || ram_data !== '0 ||
          ram_byteena !== 4'hF || rdy !== 1'b0 || init_done !== 1'b0)
        $display("FAIL init_clear step %0d: wren=%b addr=%0d data=%h be=%h ready=%b done=%b, required 1/%0d/0/f/0/0",
                 i, ram_wren, ram_address, ram_data, ram_byteena, rdy, init_done, i);
      else n_pass++;
    end
    idle(1'b1);
    n_total++;
    if (init_done !== 1'b1 || ram_wren !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL init_end: done=%b wren=%b ready=%b rsp_valid=%b, required 1/0/1/0",
               init_done, ram_wren, cmd_ready, rsp_valid);
    else n_pass++;
    zero_model();
    clear_scoreboard();
  endtask

  task automatic test_write_merge();
    logic acc, rdy, rv;
    int   c_rd;
    clear_scoreboard();
    step(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b1, acc, rdy, rv);
    n_total++;
    if (acc !== 1'b1) $display("FAIL merge_wr1_accept: accepted=%b, required 1", acc);
    else n_pass++;
    step(1'b1, 1'b1, 4'd3, 32'h000000AA, 4'b0001, 1'b1, acc, rdy, rv);
    n_total++;
    if (acc !== 1'b1) $display("FAIL merge_wr2_accept: accepted=%b, required 1", acc);
    else n_pass++;
    c_rd = cyc;
    step(1'b1, 1'b0, 4'd3, '0, '0, 1'b1, acc, rdy, rv);
    idle(1'b1);
    idle(1'b1);
    n_total++;
    if (got_q.size() != 1 || got_q[0] !== 32'hDEADBEAA)
      $display("FAIL merge_data: %0d responses, first=%h, required 1 response of deadbeaa",
               got_q.size(), got_q[0]);
    else n_pass++;
    n_total++;
    if (got_cyc_q.size() != 1 || got_cyc_q[0] != c_rd + 1)
      $display("FAIL merge_latency: response cycle %0d, required %0d", got_cyc_q[0], c_rd + 1);
    else n_pass++;
  endtask

  task automatic test_read_cleared();
    logic acc, rdy, rv;
    int   c_rd;
    clear_scoreboard();
    c_rd = cyc;
    step(1'b1, 1'b0, 4'd5, '0, '0, 1'b1, acc, rdy, rv);
    step(1'b1, 1'b0, 4'd15, '0, '0, 1'b1, acc, rdy, rv);
    idle(1'b1);
    idle(1'b1);
    n_total++;
    if (got_q.size() != 2 || got_q[0] !== '0 || got_q[1] !== '0)
      $display("FAIL cleared_data: %0d responses %h %h, required 2 responses of 0",
               got_q.size(), got_q[0], got_q[1]);
    else n_pass++;
    n_total++;
    if (got_cyc_q.size() != 2 || got_cyc_q[0] != c_rd + 1 || got_cyc_q[1] != c_rd + 2)
      $display("FAIL cleared_latency: cycles %0d %0d, required %0d %0d",
               got_cyc_q[0], got_cyc_q[1], c_rd + 1, c_rd + 2);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic             acc, rdy, rv;
    logic [WIDTH-1:0] wv [8];
    int               c0;
    int               n_acc;
    for (int i = 0; i < 8; i++) begin
      wv[i] = $urandom;
      step(1'b1, 1'b1, AW'(i), wv[i], 4'hF, 1'b1, acc, rdy, rv);
    end
    clear_scoreboard();
    c0    = cyc;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, AW'(i), '0, '0, 1'b1, acc, rdy, rv);
      if (acc) n_acc++;
    end
    idle(1'b1);
    idle(1'b1);
    n_total++;
    if (n_acc != 8) $display("FAIL b2b_ready: %0d of 8 reads accepted back to back, required 8", n_acc);
    else n_pass++;
    n_total++;
    if (got_q.size() != 8) $display("FAIL b2b_count: %0d responses, required 8", got_q.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (got_q[i] !== wv[i] || got_cyc_q[i] != c0 + 1 + i)
        $display("FAIL b2b_resp %0d: data=%h cycle=%0d, required data=%h cycle=%0d",
                 i, got_q[i], got_cyc_q[i], wv[i], c0 + 1 + i);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic             acc, rdy, rv;
    logic [WIDTH-1:0] v [4];
    logic             exp_acc [4];
    exp_acc[0] = 1'b1; exp_acc[1] = 1'b1; exp_acc[2] = 1'b0; exp_acc[3] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      v[i] = $urandom;
      step(1'b1, 1'b1, AW'(i), v[i], 4'hF, 1'b1, acc, rdy, rv);
    end
    clear_scoreboard();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, AW'((i < 2) ? i + 1 : 3), '0, '0, 1'b0, acc, rdy, rv);
      n_total++;
      if (acc !== exp_acc[i])
        $display("FAIL bp_accept %0d: accepted=%b, required %b", i, acc, exp_acc[i]);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (rv !== 1'b1 || rsp_data !== v[1])
          $display("FAIL bp_hold %0d: rsp_valid=%b data=%h, required 1 with %h", i, rv, rsp_data, v[1]);
        else n_pass++;
      end
    end
    step(1'b1, 1'b0, 4'd3, '0, '0, 1'b1, acc, rdy, rv);
    n_total++;
    if (acc !== 1'b0) $display("FAIL bp_release_full: accepted=%b, required 0", acc);
    else n_pass++;
    step(1'b1, 1'b0, 4'd3, '0, '0, 1'b1, acc, rdy, rv);
    n_total++;
    if (acc !== 1'b1) $display("FAIL bp_third_accept: accepted=%b, required 1", acc);
    else n_pass++;
    for (int i = 0; i < 3; i++) idle(1'b1);
    n_total++;
    if (got_q.size() != 3 || got_q[0] !== v[1] || got_q[1] !== v[2] || got_q[2] !== v[3])
      $display("FAIL bp_order: %0d responses %h %h %h, required %h %h %h",
               got_q.size(), got_q[0], got_q[1], got_q[2], v[1], v[2], v[3]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic acc, rdy, rv;
    int   outstanding;
    int   bad;
    clear_scoreboard();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      outstanding = exp_q.size() - got_q.size();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, DEPTH - 1)),
           $urandom, BW'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, acc, rdy, rv);
      n_total++;
      if (rdy !== (outstanding < 2)) begin
        if (bad < 5) $display("FAIL rand_ready cycle %0d: ready=%b, required %b", i, rdy, outstanding < 2);
        bad++;
      end else n_pass++;
      n_total++;
      if (rv !== (outstanding > 0)) begin
        if (bad < 5) $display("FAIL rand_rsp_valid cycle %0d: rsp_valid=%b, required %b", i, rv, outstanding > 0);
        bad++;
      end else n_pass++;
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    n_total++;
    if (got_q.size() != exp_q.size())
      $display("FAIL rand_count: %0d responses, required %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i]) begin
        if (bad < 10) $display("FAIL rand_data %0d: got %h, required %h", i, got_q[i], exp_q[i]);
        bad++;
      end else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic acc, rdy, rv;
    int   n_acc;
    step(1'b1, 1'b1, 4'd9, 32'h5A5A_1234, 4'hF, 1'b1, acc, rdy, rv);
    clear_scoreboard();
    n_acc = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 4'd9, '0, '0, 1'b0, acc, rdy, rv);
      if (acc) n_acc++;
    end
    n_total++;
    if (n_acc != 2) $display("FAIL mid_accept: %0d reads accepted, required 2", n_acc);
    else n_pass++;
    rst_drv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, rdy, rv);
      n_total++;
      if (rv !== 1'b0 || rdy !== 1'b0 || init_done !== 1'b0 || ram_wren !== 1'b0)
        $display("FAIL mid_reset_outputs %0d: rsp_valid=%b ready=%b done=%b wren=%b, required all 0",
                 i, rv, rdy, init_done, ram_wren);
      else n_pass++;
    end
    rst_drv = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, rdy, rv);
      n_total++;
      if (ram_wren !== 1'b1 || ram_address !== AW'(i) || init_done !== 1'b0)
        $display("FAIL mid_reinit step %0d: wren=%b addr=%0d done=%b, required 1/%0d/0",
                 i, ram_wren, ram_address, init_done, i);
      else n_pass++;
    end
    zero_model();
    exp_q.delete();
    step(1'b1, 1'b0, 4'd9, '0, '0, 1'b1, acc, rdy, rv);
    n_total++;
    if (init_done !== 1'b1 || acc !== 1'b1)
      $display("FAIL mid_init_end: done=%b accepted=%b, required 1/1", init_done, acc);
    else n_pass++;
    for (int i = 0; i < 3; i++) idle(1'b1);
    n_total++;
    if (got_q.size() != 1 || got_q[0] !== '0)
      $display("FAIL mid_discard: %0d responses first=%h, required exactly 1 response of 0",
               got_q.size(), got_q[0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_merge();
    test_read_cleared();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
